// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
// -----------------------------------------------------------------------------
// Purpose:
//   A UART receiver that is configured at runtime. It supports 5 to 8 data
//   bits, parity set to none, even or odd, and 1 or 2 stop bits. It rejects
//   false start bits and reports parity errors, framing errors and break
//   frames. Each received frame produces one rx_valid pulse. The data and the
//   flags are registered with that pulse and hold their values until the next
//   frame completes.
//
// Optional feature (macro UART_RX_MAJORITY_EN):
//   If the macro is defined, every bit is sampled three times, at
//   cnt = baudrate_div-2, baudrate_div-1 and baudrate_div. The bit value is
//   the 2-of-3 majority, decided at mid-bit. If the macro is undefined, each
//   bit is a single sample of rx_in taken at mid-bit, and the extra sample
//   flops are not built.
//
// Parameters:
//   DIV_W        width of baudrate_div and of the bit-period counter
//   SYNC_STAGES  number of flops in the RXD synchroniser (minimum 2)
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active high
//   baudrate_div   bit period = baudrate_div + 1 clocks (must be >= 3)
//   cfg_data_bits  data bits = 5 + cfg_data_bits
//   cfg_parity     0/2 = none, 1 = even, 3 = odd
//   cfg_stop2      0 = one stop bit, 1 = two stop bits
//   uart_rxd       asynchronous serial input, idle high
//   rx_data        received word, LSB-aligned, unused MSBs are zero
//   rx_valid       one-cycle pulse when a frame is complete
//   rx_parity_err  parity mismatch (qualified by rx_valid)
//   rx_frame_err   a stop-bit sample was 0 (qualified by rx_valid)
//   rx_break       break frame (qualified by rx_valid)
//   rx_busy        high in every state except IDLE
//
// Handshake: there is no back-pressure. rx_valid is a single-cycle strobe,
// and the consumer must take rx_data and the flags in that cycle or before
// the next strobe. The receiver never waits for the consumer.
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baudrate_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             uart_rxd,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_break,
    output logic             rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------
    // Synchroniser and edge detection
    // ------------------------------------------------------------------
    // The chain resets to all ones so that the line reads as idle. This
    // keeps reset release from looking like a start bit.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx_in;
    logic                   w_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], uart_rxd};
            r_rx_prev <= w_rx_in;
        end
    end

    assign w_rx_in = r_sync[SYNC_STAGES-1];
    // r_rx_prev updates in every state. A falling edge that arrives in the
    // same cycle as the rx_valid pulse is therefore still seen in IDLE.
    assign w_fall  = r_rx_prev & ~w_rx_in;

    // ------------------------------------------------------------------
    // Bit-period counter
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_cnt;
    logic             w_mid;
    logic             w_start_det;

    assign w_mid       = (r_cnt == baudrate_div);
    assign w_start_det = (r_state == S_IDLE) && w_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            // Start at half a period so that the first mid falls in the
            // centre of the start bit.
            if (w_fall) begin
                r_cnt <= baudrate_div >> 1;
            end
        end else if (w_mid) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Bit value decision
    // ------------------------------------------------------------------
    logic w_bit;

`ifdef UART_RX_MAJORITY_EN
    logic r_samp0;
    logic r_samp1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp0 <= 1'b1;
            r_samp1 <= 1'b1;
        end else begin
            if (r_cnt == (baudrate_div - DIV_W'(2))) begin
                r_samp0 <= w_rx_in;
            end
            if (r_cnt == (baudrate_div - DIV_W'(1))) begin
                r_samp1 <= w_rx_in;
            end
        end
    end

    // The third sample is the live rx_in at mid, so the decision is made
    // in the same cycle as in the single-sample build.
    assign w_bit = (r_samp0 & r_samp1) | (r_samp0 & w_rx_in) | (r_samp1 & w_rx_in);
`else
    assign w_bit = w_rx_in;
`endif

    // ------------------------------------------------------------------
    // Frame configuration, latched at start detect
    // ------------------------------------------------------------------
    logic [1:0] r_data_bits;
    logic [1:0] r_parity;
    logic       r_stop2;

    // ------------------------------------------------------------------
    // Frame datapath state
    // ------------------------------------------------------------------
    logic [7:0] r_shift;      // data enters at the MSB and moves down (LSB first on the line)
    logic [2:0] r_bit_idx;
    logic       r_par_acc;    // XOR of the data bits received so far
    logic       r_par_err;
    logic       r_all_zero;   // every data bit and the parity bit seen so far were 0
    logic       r_frame_err;
    logic       r_break;
    logic       r_stop_idx;

    logic       w_last_data;
    logic       w_last_stop;
    logic       w_frame_now;
    logic       w_break_now;
    logic [2:0] w_align_sh;
    logic [7:0] w_aligned;

    // Index of the last data bit is N-1 = 4 + cfg_data_bits.
    assign w_last_data = (r_bit_idx == (3'd4 + {1'b0, r_data_bits}));
    assign w_last_stop = (r_stop_idx == r_stop2);
    assign w_frame_now = r_frame_err | ~w_bit;
    // Break is decided on the first stop bit. A second stop bit only
    // contributes to the frame error.
    assign w_break_now = (r_stop_idx == 1'b0) ? (r_all_zero & ~w_bit) : r_break;
    // After N shifts the word occupies r_shift[7:8-N]. Shift it right by
    // 8-N to LSB-align it. The low bits were cleared at start, so the MSBs
    // of the result are zero.
    assign w_align_sh  = 3'd3 - {1'b0, r_data_bits};
    assign w_aligned   = r_shift >> w_align_sh;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_mid) begin
                    // If the line is high again at mid-start, the low pulse
                    // was a glitch. Drop it without producing a frame.
                    w_next_state = w_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_mid && w_last_data) begin
                    w_next_state = r_parity[0] ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_mid) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_mid && w_last_stop) begin
                    // After a framing error the line may still be low, for
                    // example during a break. Wait for it to go high so
                    // that a held-low line produces only one frame.
                    w_next_state = w_frame_now ? S_WAIT_IDLE : S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_in) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_bits   <= 2'd0;
            r_parity      <= 2'd0;
            r_stop2       <= 1'b0;
            r_shift       <= 8'd0;
            r_bit_idx     <= 3'd0;
            r_par_acc     <= 1'b0;
            r_par_err     <= 1'b0;
            r_all_zero    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_break       <= 1'b0;
            r_stop_idx    <= 1'b0;
            rx_data       <= 8'd0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (w_start_det) begin
                r_data_bits <= cfg_data_bits;
                r_parity    <= cfg_parity;
                r_stop2     <= cfg_stop2;
                r_shift     <= 8'd0;
                r_bit_idx   <= 3'd0;
                r_par_acc   <= 1'b0;
                r_par_err   <= 1'b0;
                r_all_zero  <= 1'b1;
                r_frame_err <= 1'b0;
                r_break     <= 1'b0;
                r_stop_idx  <= 1'b0;
            end

            if (w_mid) begin
                case (r_state)
                    S_DATA: begin
                        r_shift    <= {w_bit, r_shift[7:1]};
                        r_bit_idx  <= r_bit_idx + 3'd1;
                        r_par_acc  <= r_par_acc ^ w_bit;
                        r_all_zero <= r_all_zero & ~w_bit;
                    end
                    S_PARITY: begin
                        // Even parity: an error when XOR(data, bit) = 1.
                        // Odd parity (r_parity[1] set): inverted.
                        r_par_err  <= r_par_acc ^ w_bit ^ r_parity[1];
                        r_all_zero <= r_all_zero & ~w_bit;
                    end
                    S_STOP: begin
                        r_frame_err <= w_frame_now;
                        r_break     <= w_break_now;
                        r_stop_idx  <= 1'b1;
                        if (w_last_stop) begin
                            rx_valid      <= 1'b1;
                            rx_data       <= w_break_now ? 8'd0 : w_aligned;
                            rx_parity_err <= r_par_err;
                            rx_frame_err  <= w_frame_now;
                            rx_break      <= w_break_now;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_busy = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver, successor to the fixed 8N1 receiver in the UART block. Adds 5–8 data bits, none/even/odd parity and 1 or 2 stop bits. Also adds false-start rejection, per-frame parity and framing error flags, and break detection. Sits between the synchronised RXD pin and the UART RX FIFO / register interface; one frame in, one `rx_valid` pulse out.

Parameters:
- `DIV_W`, 16, width of `baudrate_div` and of the bit-period counter.
- `SYNC_STAGES`, 3, flip-flops in the RXD synchroniser chain (min 2).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `baudrate_div`  in  `DIV_W`  bit period = `baudrate_div`+1 clocks; must be ≥ 3
- `cfg_data_bits`  in  2  data bits = 5 + `cfg_data_bits` (0→5 … 3→8)
- `cfg_parity`  in  2  0/2 = none, 1 = even, 3 = odd
- `cfg_stop2`  in  1  0 = one stop bit, 1 = two stop bits
- `uart_rxd`  in  1  asynchronous serial input, idle high
- `rx_data`  out  8  received word, LSB-aligned, unused MSBs zero
- `rx_valid`  out  1  one-cycle pulse, frame complete
- `rx_parity_err`  out  1  parity mismatch on the frame; valid with `rx_valid`
- `rx_frame_err`  out  1  any stop-bit sample was 0; valid with `rx_valid`
- `rx_break`  out  1  break frame; valid with `rx_valid`
- `rx_busy`  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous, active-high.
- Synchroniser:
  - `SYNC_STAGES` flops, reset to all ones (line idle; no false start after reset).
  - `rx_in` is the last stage.
  - Falling edge = previous `rx_in` 1, current `rx_in` 0.
- Bit counter `cnt` (`DIV_W` bits):
  - "mid" when `cnt == baudrate_div`; then `cnt` ← 0, else `cnt`+1.
  - On start detect `cnt` ← `baudrate_div`>>1, so the first mid lands at half a bit period.
- Reset values:
  - All outputs 0.
  - State IDLE, `cnt` = 0, shift register 0.
  - Reset mid-frame aborts the frame with no `rx_valid`.
- Config latching: `cfg_*` are latched on start detect and held for the whole frame. Changes mid-frame have no effect on that frame.
- States:
  - IDLE: wait for falling edge → START.
  - START: at mid, if `rx_in` = 1 (glitch) → IDLE, no output; else → DATA, bit index 0.
  - DATA: at each mid, shift `rx_in` in LSB-first. After N bits → PARITY if parity enabled, else STOP.
  - PARITY: at mid, sample the parity bit.
    - Even: error if XOR(data, bit) = 1.
    - Odd: error if XOR(data, bit) = 0.
    - Then → STOP.
  - STOP: one or two mids. Any stop sample of 0 sets the frame error. After the last stop mid:
    - Register the outputs and pulse `rx_valid` on the next cycle (latency one cycle after the last stop-bit sample).
    - → WAIT_IDLE if the frame error is set, else → IDLE.
  - WAIT_IDLE: stay until `rx_in` = 1, then → IDLE. No edge detection in this state, so a held-low line yields exactly one frame.
- Frames with errors are still delivered: `rx_data` plus flags with `rx_valid`.
- Break:
  - Condition: all data bits, the parity bit (if any) and the first stop bit are 0.
  - Outputs: `rx_break` = 1, `rx_frame_err` = 1, `rx_data` = 0.
- Data alignment: for N < 8, the shift result is right-aligned; bits [7:N] = 0.
- Flag persistence:
  - `rx_data` and the flags hold their values until the next `rx_valid`.
  - `rx_valid` is high for exactly one cycle per frame.
- Simultaneous events: a falling edge arriving in the same cycle as the `rx_valid` pulse (back-to-back frames, 1 stop bit, state → IDLE) is detected. The edge check in IDLE uses the registered previous `rx_in`, so no frame is lost.

Optional Feature:
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Each bit (start, data, parity, stop) is sampled at `cnt` = `baudrate_div`−2, −1 and `baudrate_div`.
  - The bit value is the majority of 3, decided at mid.
  - Start-bit rejection uses the majority value.
  - `baudrate_div` ≥ 3 is required.
- Undefined: single sample of `rx_in` at mid. No extra sample registers are instantiated.

Test Plan:
- Default conditions for all scenarios: `baudrate_div` = 15 (16 clk/bit); config 8N1 unless stated.
- 8N1, send 0xA5 → `rx_data` = 0xA5, exactly one `rx_valid` pulse, all flags 0; `rx_busy` returns to 0 after the stop bit.
- 7E1 (`cfg_data_bits` = 2, `cfg_parity` = 1), send 0x35 with parity bit 1 → `rx_data` = 0x35, `rx_parity_err` = 1. Repeat with parity bit 0 → `rx_parity_err` = 0.
- 8N2, send 0x3C with second stop bit 0 → `rx_data` = 0x3C, `rx_frame_err` = 1. Hold the line high afterwards, then send 0x81 → `rx_data` = 0x81, flags 0.
- Break: hold `uart_rxd` low for 20 bit times, then high → exactly one `rx_valid` with `rx_data` = 0x00, `rx_break` = 1, `rx_frame_err` = 1. Then a 0x55 frame is received cleanly.
- Glitch: low pulse of 5 clocks → no `rx_valid`, state returns to IDLE. Then assert `rst` mid-frame during 0xFF → outputs 0, no `rx_valid`, and the next frame 0x12 is received correctly.
- With `UART_RX_MAJORITY_EN`, send 0x5A with a 1-clock inverted glitch at the mid sample of bit 3 → `rx_data` = 0x5A, flags 0.
